// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the multi-cycle fetch/execute sequencer.
// The decoder's opcode/funct encodings live elsewhere; this package only
// describes the sequencer's own state machine.
package fetch_sequencer_pkg;

   // Instruction word width of the 9-bit core.
   localparam int INST_W = 9;

   // Sequencer states, 3-bit encoding.
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_EXEC     = 3'd2,
      S_MEM_WAIT = 3'd3,
      S_HALTED   = 3'd4
   } seq_state_t;

   // True in the states that make up a running program.
   function automatic logic is_busy(input seq_state_t s);
      return (s == S_FETCH) || (s == S_EXEC) || (s == S_MEM_WAIT);
   endfunction

endpackage : fetch_sequencer_pkg

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over enable; once the count reaches all-ones it stays there
// until cleared or reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] MAX = {W{1'b1}};

   // Count register: reset, clear, or saturating increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != MAX)) begin
         count <= count + ONE;
      end
   end

endmodule : sat_counter

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute sequencer for the 9-bit core.
// Owns the program counter and the instruction register so the decoder
// always sees a stable instruction. Each instruction takes FETCH + EXEC,
// plus one MEM_WAIT cycle for synchronous data-memory reads. exec_en is
// the single-cycle commit strobe for register-file and data-memory writes.
// state_dbg exposes the FSM state for observation.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int PC_W  = 10,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [PC_W-1:0]   start_addr,
   input  logic [INST_W-1:0] inst_in,
   input  logic              ctrl_branch,
   input  logic              take_branch,
   input  logic [PC_W-1:0]   branch_target,
   input  logic              ctrl_mem_read,
   input  logic              halt,
   output logic [PC_W-1:0]   pc,
   output logic [INST_W-1:0] inst_out,
   output logic              exec_en,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  cycle_count,
   output seq_state_t        state_dbg
);

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   seq_state_t      state_q;
   seq_state_t      state_d;
   logic            load_start;
   logic            capture_ir;
   logic            commit;
   logic [PC_W-1:0] next_pc;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-state control decode. halt outranks ctrl_mem_read
   // in EXEC; neither commits. start is only looked at in IDLE and HALTED.
   always_comb begin
      state_d    = state_q;
      load_start = 1'b0;
      capture_ir = 1'b0;
      commit     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load_start = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_FETCH: begin
            capture_ir = 1'b1;
            state_d    = S_EXEC;
         end
         S_EXEC: begin
            if (halt) begin
               state_d = S_HALTED;
            end else if (ctrl_mem_read) begin
               state_d = S_MEM_WAIT;
            end else begin
               commit  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEM_WAIT: begin
            commit  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALTED: begin
            if (start) begin
               load_start = 1'b1;
               state_d    = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Taken branches jump to the absolute target; everything else steps by
   // one and wraps naturally at the PC width.
   always_comb begin
      next_pc = pc + PC_ONE;
      if (ctrl_branch && take_branch) begin
         next_pc = branch_target;
      end
   end

   // Program counter: loaded on an accepted start, advanced on commit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc <= '0;
      end else if (load_start) begin
         pc <= start_addr;
      end else if (commit) begin
         pc <= next_pc;
      end
   end

   // Instruction register: captures ROM data at the end of FETCH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inst_out <= '0;
      end else if (capture_ir) begin
         inst_out <= inst_in;
      end
   end

   // Cycle counter: cleared on an accepted start, counts busy cycles.
   sat_counter #(
      .W (CNT_W)
   ) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (load_start),
      .en    (busy),
      .count (cycle_count)
   );

   // The commit strobe is masked by reset so no write slips through on a
   // reset edge, even if reset lands in EXEC or MEM_WAIT.
   assign exec_en   = commit & rst_n;
   assign busy      = is_busy(state_q);
   assign done      = (state_q == S_HALTED);
   assign state_dbg = state_q;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of single-instruction
// vectors plus hand-written multi-cycle sequences.
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- main DUT (PC_W=10, CNT_W=16) ----------------
   logic        start;
   logic [9:0]  start_addr;
   logic [8:0]  inst_in;
   logic        ctrl_branch, take_branch, ctrl_mem_read, halt;
   logic [9:0]  branch_target;
   logic [9:0]  pc;
   logic [8:0]  inst_out;
   logic        exec_en, busy, done;
   logic [15:0] cycle_count;
   seq_state_t  state_dbg;

   fetch_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .inst_in(inst_in), .ctrl_branch(ctrl_branch), .take_branch(take_branch),
      .branch_target(branch_target), .ctrl_mem_read(ctrl_mem_read), .halt(halt),
      .pc(pc), .inst_out(inst_out), .exec_en(exec_en), .busy(busy), .done(done),
      .cycle_count(cycle_count), .state_dbg(state_dbg)
   );

   // ---------------- small DUT (PC_W=4, CNT_W=4) ----------------
   logic        start_s;
   logic [3:0]  start_addr_s;
   logic [8:0]  inst_in_s;
   logic        ctrl_branch_s, ctrl_mem_read_s, halt_s;
   logic [3:0]  branch_target_s;
   logic [3:0]  pc_s;
   logic [8:0]  inst_out_s;
   logic        exec_en_s, busy_s, done_s;
   logic [3:0]  cycle_count_s;
   seq_state_t  state_dbg_s;

   fetch_sequencer #(.PC_W(4), .CNT_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start_s), .start_addr(start_addr_s),
      .inst_in(inst_in_s), .ctrl_branch(ctrl_branch_s), .take_branch(take_branch),
      .branch_target(branch_target_s), .ctrl_mem_read(ctrl_mem_read_s), .halt(halt_s),
      .pc(pc_s), .inst_out(inst_out_s), .exec_en(exec_en_s), .busy(busy_s), .done(done_s),
      .cycle_count(cycle_count_s), .state_dbg(state_dbg_s)
   );

   // ---------------- ROM and decoder models ----------------
   // Encoding used by the bench: [8:6]=111 HALT, 110 load, 101 branch, else ALU.
   localparam logic [8:0] I_HALT = 9'h1C0;
   localparam logic [8:0] I_LOAD = 9'h180;
   localparam logic [8:0] I_BR   = 9'h140;

   logic [8:0] rom   [0:1023];
   logic [8:0] rom_s [0:15];
   assign inst_in         = rom[pc];
   assign inst_in_s       = rom_s[pc_s];
   assign halt            = (inst_out[8:6] == 3'b111);
   assign ctrl_mem_read   = (inst_out[8:6] == 3'b110);
   assign ctrl_branch     = (inst_out[8:6] == 3'b101);
   assign halt_s          = (inst_out_s[8:6] == 3'b111);
   assign ctrl_mem_read_s = (inst_out_s[8:6] == 3'b110);
   assign ctrl_branch_s   = (inst_out_s[8:6] == 3'b101);
   assign branch_target_s = branch_target[3:0];

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      start_s = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [9:0]  addr;
      logic [8:0]  inst;
      logic        take;
      logic [9:0]  target;
      logic [9:0]  exp_pc;
      int          exp_execs;
      logic [15:0] exp_count;
   } vec_t;

   vec_t vecs[7];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [8:0] mask;
      int         execs;
      logic       fetched;

      for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
      for (int i = 0; i < 16; i++) rom_s[i] = 9'h000;
      start = 1'b0; start_s = 1'b0;
      start_addr = '0; start_addr_s = '0;
      take_branch = 1'b0; branch_target = '0;

      // ---- reset state ----
      do_reset();
      check("rst_pc", 32'(pc), 0);
      check("rst_inst", 32'(inst_out), 0);
      check("rst_count", 32'(cycle_count), 0);
      check("rst_flags", {29'd0, exec_en, busy, done}, 0);
      check("rst_state", 32'(state_dbg), 32'(S_IDLE));
      check("rst_small_flags", {29'd0, exec_en_s, busy_s, done_s}, 0);
      tick(); tick();
      check("idle_hold", {29'd0, busy, done, (state_dbg == S_IDLE)}, 1);

      // ---- table of single-instruction vectors ----
      vecs[0] = '{10'd5,    9'h012, 1'b0, 10'd0,    10'd6,    1, 16'd2};
      vecs[1] = '{10'd10,   I_BR,   1'b1, 10'd3,    10'd3,    1, 16'd2};
      vecs[2] = '{10'd10,   I_BR,   1'b0, 10'd3,    10'd11,   1, 16'd2};
      vecs[3] = '{10'd4,    I_LOAD, 1'b0, 10'd0,    10'd5,    1, 16'd3};
      vecs[4] = '{10'd1023, 9'h021, 1'b0, 10'd0,    10'd0,    1, 16'd2};
      vecs[5] = '{10'd20,   9'h033, 1'b1, 10'd7,    10'd21,   1, 16'd2};
      vecs[6] = '{10'd30,   I_BR,   1'b1, 10'd1023, 10'd1023, 1, 16'd2};

      for (int v = 0; v < 7; v++) begin
         do_reset();
         rom[vecs[v].addr] = vecs[v].inst;
         take_branch   = vecs[v].take;
         branch_target = vecs[v].target;
         start_addr    = vecs[v].addr;
         start = 1'b1;
         tick();
         start = 1'b0;
         check($sformatf("v%0d_fetch_pc", v), 32'(pc), 32'(vecs[v].addr));
         execs = 0;
         fetched = 1'b0;
         for (int c = 0; c < 10 && !fetched; c++) begin
            if (exec_en) execs++;
            tick();
            if (state_dbg == S_FETCH) fetched = 1'b1;
         end
         check($sformatf("v%0d_refetch", v), 32'(fetched), 1);
         check($sformatf("v%0d_next_pc", v), 32'(pc), 32'(vecs[v].exp_pc));
         check($sformatf("v%0d_execs", v), 32'(execs), 32'(vecs[v].exp_execs));
         check($sformatf("v%0d_count", v), 32'(cycle_count), 32'(vecs[v].exp_count));
         rom[vecs[v].addr] = 9'h000;
      end
      take_branch = 1'b0;
      branch_target = '0;

      // ---- straight-line run, start held high throughout ----
      do_reset();
      rom[5] = 9'h012; rom[6] = 9'h034; rom[7] = 9'h056; rom[8] = I_HALT;
      rom[2] = 9'h000; rom[3] = I_LOAD;
      exp_q.delete();
      exp_q.push_back(10'd5); exp_q.push_back(10'd6);
      exp_q.push_back(10'd7); exp_q.push_back(10'd8);
      start_addr = 10'd5;
      start = 1'b1;
      tick();
      start_addr = 10'd2;   // must not be picked up while busy
      mask = '0;
      for (int k = 1; k <= 8; k++) begin
         mask[k] = exec_en;
         check($sformatf("sl_busy_c%0d", k), 32'(busy), 1);
         if (state_dbg == S_FETCH && exp_q.size() > 0)
            check($sformatf("sl_fetch_pc_c%0d", k), 32'(pc), 32'(exp_q.pop_front()));
         tick();
      end
      check("sl_exec_mask", 32'(mask), 32'h054);
      check("sl_fetch_seen", 32'(exp_q.size()), 0);
      check("sl_done", {30'd0, done, busy}, 32'h2);
      check("sl_count", 32'(cycle_count), 8);
      check("sl_pc", 32'(pc), 8);
      check("sl_inst", 32'(inst_out), 32'(I_HALT));
      check("sl_halt_no_exec", 32'(exec_en), 0);

      // start still high in HALTED: restart at start_addr=2
      tick();
      start = 1'b0;
      check("rs_state", 32'(state_dbg), 32'(S_FETCH));
      check("rs_pc", 32'(pc), 2);
      check("rs_count", 32'(cycle_count), 0);
      check("rs_done", 32'(done), 0);

      // ---- reset in MEM_WAIT ----
      tick();               // EXEC @2 (ALU)
      check("mw_exec_alu", 32'(exec_en), 1);
      tick();               // FETCH @3
      check("mw_fetch_pc", 32'(pc), 3);
      tick();               // EXEC @3 (load)
      check("mw_exec_load", 32'(exec_en), 0);
      tick();               // MEM_WAIT
      check("mw_state", 32'(state_dbg), 32'(S_MEM_WAIT));
      check("mw_commit", 32'(exec_en), 1);
      check("mw_count", 32'(cycle_count), 4);
      rst_n = 1'b0;
      #1;
      check("mw_rst_no_commit", 32'(exec_en), 0);
      tick();
      check("mw_rst_state", 32'(state_dbg), 32'(S_IDLE));
      check("mw_rst_pc", 32'(pc), 0);
      check("mw_rst_flags", {29'd0, exec_en, busy, done}, 0);
      check("mw_rst_count", 32'(cycle_count), 0);
      check("mw_rst_inst", 32'(inst_out), 0);
      rst_n = 1'b1;

      // ---- small DUT: PC wrap and counter saturation ----
      do_reset();
      start_addr_s = 4'd15;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      check("sm_fetch_pc", 32'(pc_s), 15);
      tick();
      check("sm_exec", 32'(exec_en_s), 1);
      tick();
      check("sm_wrap_pc", 32'(pc_s), 0);
      check("sm_count2", 32'(cycle_count_s), 2);
      for (int i = 0; i < 12; i++) tick();
      check("sm_count14", 32'(cycle_count_s), 14);
      for (int i = 0; i < 6; i++) tick();
      check("sm_count_sat", 32'(cycle_count_s), 15);
      check("sm_busy", 32'(busy_s), 1);
      do_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fetch_sequencer
